id_ex_alu_issue: RTL
====================

Name: id_ex_alu_issue

Overview:
- ID/EX pipeline stage that drives the EX-stage ALU's operand and control interface.
- Each cycle it registers decoded operands, immediate, ALUSrc, ALUOp and funct from ID.
- It generates the 4-bit ALU control code and applies EX-stage forwarding.
- Outputs: ALU operand 1, ALU operand 2, store data and a valid flag. Supports stall (hold) and flush (bubble insertion).

Parameters:
- DATA_WIDTH, 32, width of operands, immediate and forwarded data.
- CTRL_WIDTH, 4, width of the ALU control code.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous active-high reset.
- Stall_ID_EX  input  1  hold stage register contents.
- Flush_ID_EX  input  1  load a bubble into the stage register.
- Instruction_Valid_ID  input  1  ID holds a real instruction.
- Read_Data_1_ID  input  DATA_WIDTH  register file port 1.
- Read_Data_2_ID  input  DATA_WIDTH  register file port 2.
- Sign_Extend_ID  input  DATA_WIDTH  sign-extended immediate.
- ALUSrc_ID  input  1  1 selects the immediate as ALU operand 2.
- ALUOp_ID  input  2  main-decoder ALU operation class.
- Funct_ID  input  6  R-type funct field.
- Forward_A_EX  input  2  operand 1 forward select.
- Forward_B_EX  input  2  operand 2 forward select.
- ALU_Result_MEM  input  DATA_WIDTH  EX/MEM ALU result.
- Write_Data_WB  input  DATA_WIDTH  WB write-back data.
- Read_Data_1_EX  output  DATA_WIDTH  ALU operand 1.
- ALU_Data_2_EX  output  DATA_WIDTH  ALU operand 2.
- Write_Data_EX  output  DATA_WIDTH  forwarded register 2 value (store data).
- ALU_Control_EX  output  CTRL_WIDTH  ALU operation code.
- Valid_EX  output  1  EX holds a real instruction.
- Illegal_Funct_EX  output  1  R-type funct not supported.

Behaviour:
- Stage register captures: Instruction_Valid, both register reads, immediate, ALUSrc, ALU control code, illegal flag.
- Register priority per rising Clk edge: Reset > Flush_ID_EX > Stall_ID_EX > load.
  - Reset or Flush: data fields 0, ALUSrc 0, control 4'b0010, Valid 0, Illegal 0. Flush during stall still bubbles.
  - Stall (no flush): all fields hold.
  - Otherwise: load from ID inputs. Latency is 1 cycle from ID inputs to EX outputs.
- ALU control decode is combinational on ID inputs and registered:
  - ALUOp 00 -> 0010 (add).
  - ALUOp 01 -> 0110 (sub).
  - ALUOp 11 -> 0001 (or, ori).
  - ALUOp 10 -> by funct: 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111.
  - Any other funct under ALUOp 10 -> control 0010 and Illegal 1.
  - Illegal is only set when the loaded Instruction_Valid_ID=1.
- Forwarding is combinational on registered operands and current-cycle forward inputs:
  - Select 00 -> registered value; 10 -> ALU_Result_MEM; 01 -> Write_Data_WB; 11 -> registered value (reserved).
  - Operand A = Read_Data_1_EX.
  - Forwarded B = Write_Data_EX.
  - ALU_Data_2_EX = registered ALUSrc ? registered immediate : forwarded B.
- Outputs after reset (selects 00): all data 0, ALU_Control_EX 0010, Valid_EX 0, Illegal_Funct_EX 0.
- Forward selects are honoured regardless of Valid_EX.
- No arithmetic in this block; all data paths are DATA_WIDTH with no truncation.

Optional Feature:
- Macro: ID_EX_FORWARDING_EN.
- Defined: forwarding muxes as above.
- Undefined:
  - Forward_A_EX, Forward_B_EX, ALU_Result_MEM and Write_Data_WB are ignored.
  - Read_Data_1_EX and Write_Data_EX come directly from the stage register; ALU_Data_2_EX uses the registered B when ALUSrc=0.
  - Ports remain present.

Test Plan:
- Reset held 2 cycles, then released with ID inputs idle -> all data outputs 0, ALU_Control_EX 0010, Valid_EX 0.
- Load R-type with RD1=5, RD2=3, ALUOp 10, funct 100010, valid 1 -> next cycle Read_Data_1_EX=5, ALU_Data_2_EX=3, ALU_Control_EX 0110, Valid_EX 1.
- Load with ALUOp 10, funct 101010, then 100111 -> 0111 with Illegal 0, then 0010 with Illegal 1.
- Load lw with ALUSrc 1, imm=0xFFFFFFFC, RD2=7 -> ALU_Data_2_EX=0xFFFFFFFC, Write_Data_EX=7, control 0010.
- Load RD1=1, hold Stall 3 cycles while ID changes to RD1=9 -> outputs stay 1; assert Flush together with Stall -> next cycle Valid_EX 0, data 0, control 0010.
- Forwarding with macro defined, registered RD1=1, RD2=2, ALU_Result_MEM=0xAA, Write_Data_WB=0xBB:
  - Forward_A=10, Forward_B=01 -> Read_Data_1_EX=0xAA, Write_Data_EX=0xBB.
  - Forward_A=11 -> Read_Data_1_EX=1.
  - Macro undefined -> Read_Data_1_EX=1, Write_Data_EX=2.

Source files
------------

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: ID/EX stage register feeding the EX-stage ALU.
// Registers the decoded operands, immediate, ALUSrc, ALU control code and illegal-funct flag.
// The ALU control code is decoded from ALUOp/funct in ID before it is registered.
// Operand forwarding from MEM/WB is built only when ID_EX_FORWARDING_EN is defined.
// Without that macro, the forwarding inputs are accepted but ignored.
module id_ex_alu_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall_ID_EX,
    input  logic                  Flush_ID_EX,
    input  logic                  Instruction_Valid_ID,
    input  logic [DATA_WIDTH-1:0] Read_Data_1_ID,
    input  logic [DATA_WIDTH-1:0] Read_Data_2_ID,
    input  logic [DATA_WIDTH-1:0] Sign_Extend_ID,
    input  logic                  ALUSrc_ID,
    input  logic [1:0]            ALUOp_ID,
    input  logic [5:0]            Funct_ID,
    input  logic [1:0]            Forward_A_EX,
    input  logic [1:0]            Forward_B_EX,
    input  logic [DATA_WIDTH-1:0] ALU_Result_MEM,
    input  logic [DATA_WIDTH-1:0] Write_Data_WB,
    output logic [DATA_WIDTH-1:0] Read_Data_1_EX,
    output logic [DATA_WIDTH-1:0] ALU_Data_2_EX,
    output logic [DATA_WIDTH-1:0] Write_Data_EX,
    output logic [CTRL_WIDTH-1:0] ALU_Control_EX,
    output logic                  Valid_EX,
    output logic                  Illegal_Funct_EX
);

    localparam logic [CTRL_WIDTH-1:0] CTRL_AND = CTRL_WIDTH'(4'b0000);
    localparam logic [CTRL_WIDTH-1:0] CTRL_OR  = CTRL_WIDTH'(4'b0001);
    localparam logic [CTRL_WIDTH-1:0] CTRL_ADD = CTRL_WIDTH'(4'b0010);
    localparam logic [CTRL_WIDTH-1:0] CTRL_SUB = CTRL_WIDTH'(4'b0110);
    localparam logic [CTRL_WIDTH-1:0] CTRL_SLT = CTRL_WIDTH'(4'b0111);

    // Returns {illegal, ctrl}. An unsupported R-type funct falls back to add.
    // It is flagged illegal only when ID holds a real instruction.
    function automatic logic [CTRL_WIDTH:0] alu_decode(input logic [1:0] op,
                                                       input logic [5:0] funct,
                                                       input logic       valid);
        logic [CTRL_WIDTH-1:0] ctrl;
        logic                  ill;
        ctrl = CTRL_ADD;
        ill  = 1'b0;
        case (op)
            2'b00: ctrl = CTRL_ADD;
            2'b01: ctrl = CTRL_SUB;
            2'b11: ctrl = CTRL_OR;
            default: begin
                case (funct)
                    6'b100000: ctrl = CTRL_ADD;
                    6'b100010: ctrl = CTRL_SUB;
                    6'b100100: ctrl = CTRL_AND;
                    6'b100101: ctrl = CTRL_OR;
                    6'b101010: ctrl = CTRL_SLT;
                    default: begin
                        ctrl = CTRL_ADD;
                        ill  = valid;
                    end
                endcase
            end
        endcase
        return {ill, ctrl};
    endfunction

    logic                  valid_q,   valid_d;
    logic [DATA_WIDTH-1:0] rd1_q,     rd1_d;
    logic [DATA_WIDTH-1:0] rd2_q,     rd2_d;
    logic [DATA_WIDTH-1:0] imm_q,     imm_d;
    logic                  alusrc_q,  alusrc_d;
    logic [CTRL_WIDTH-1:0] ctrl_q,    ctrl_d;
    logic                  illegal_q, illegal_d;

    logic [CTRL_WIDTH-1:0] ctrl_id;
    logic                  illegal_id;

    // Decode the ALU control code from the ID-stage inputs.
    always_comb begin
        {illegal_id, ctrl_id} = alu_decode(ALUOp_ID, Funct_ID, Instruction_Valid_ID);
    end

    // Next stage contents: a flush bubbles even while stalled, a stall holds, otherwise load from ID.
    always_comb begin
        valid_d   = valid_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        imm_d     = imm_q;
        alusrc_d  = alusrc_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        if (Flush_ID_EX) begin
            valid_d   = 1'b0;
            rd1_d     = '0;
            rd2_d     = '0;
            imm_d     = '0;
            alusrc_d  = 1'b0;
            ctrl_d    = CTRL_ADD;
            illegal_d = 1'b0;
        end else if (!Stall_ID_EX) begin
            valid_d   = Instruction_Valid_ID;
            rd1_d     = Read_Data_1_ID;
            rd2_d     = Read_Data_2_ID;
            imm_d     = Sign_Extend_ID;
            alusrc_d  = ALUSrc_ID;
            ctrl_d    = ctrl_id;
            illegal_d = illegal_id;
        end
    end

    // Stage register. Reset loads the same bubble as a flush.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q   <= 1'b0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            alusrc_q  <= 1'b0;
            ctrl_q    <= CTRL_ADD;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            imm_q     <= imm_d;
            alusrc_q  <= alusrc_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;

`ifdef ID_EX_FORWARDING_EN
    // Forwarding muxes. Selects are honoured even for a bubble; 11 is reserved and keeps the register value.
    always_comb begin
        fwd_a = rd1_q;
        fwd_b = rd2_q;
        case (Forward_A_EX)
            2'b10:   fwd_a = ALU_Result_MEM;
            2'b01:   fwd_a = Write_Data_WB;
            default: fwd_a = rd1_q;
        endcase
        case (Forward_B_EX)
            2'b10:   fwd_b = ALU_Result_MEM;
            2'b01:   fwd_b = Write_Data_WB;
            default: fwd_b = rd2_q;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{Forward_A_EX, Forward_B_EX, ALU_Result_MEM, Write_Data_WB};

    // Without forwarding, operands come straight from the stage register.
    always_comb begin
        fwd_a = rd1_q;
        fwd_b = rd2_q;
    end
`endif

    // Drive the EX-side outputs. Operand 2 takes the immediate when ALUSrc is set.
    always_comb begin
        Read_Data_1_EX   = fwd_a;
        Write_Data_EX    = fwd_b;
        ALU_Data_2_EX    = alusrc_q ? imm_q : fwd_b;
        ALU_Control_EX   = ctrl_q;
        Valid_EX         = valid_q;
        Illegal_Funct_EX = illegal_q;
    end

endmodule
